// File: rtl/pe_fifo_pkg.sv
// Shared types and helpers for the PE row FIFO bank: pixel-vector shape,
// pop-mode encoding and the occupancy-counter width function.
package pe_fifo_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int PIX_N_DEF = 7;

    typedef logic [PIX_N_DEF-1:0][PIX_W_DEF-1:0] pix_vec_t;

    typedef enum logic {
        POP_INDEPENDENT = 1'b0,
        POP_LOCKSTEP    = 1'b1
    } pop_mode_e;

    // Bits of one pixel vector for an arbitrary (data_width, cols) shape.
    function automatic int pix_vec_bits(input int data_width, input int cols);
        return data_width * cols;
    endfunction

    // Counter width able to hold 0..depth inclusive.
    function automatic int cw_calc(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pe_row_fifo_bank_if.sv
// Push/pop bus between the PE array, the row FIFO bank and the row-buffer reader.
interface pe_row_fifo_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int COLS       = 7,
    parameter int DEPTH      = 16
);
    import pe_fifo_pkg::*;

    localparam int CW = cw_calc(DEPTH);

    logic                                        clear;
    logic [ROWS-1:0]                             wr_en;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]   wr_data;
    logic [ROWS-1:0]                             full;
    logic [ROWS-1:0]                             almost_full;
    logic                                        lockstep;
    logic [ROWS-1:0]                             rd_en;
    logic                                        rd_ready;
    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]   rd_data;
    logic [ROWS-1:0]                             rd_valid;
    logic                                        data_valid;
    logic [ROWS-1:0][CW-1:0]                     count;
    logic                                        overflow;

    modport master (
        output clear, wr_en, wr_data, lockstep, rd_en, rd_ready,
        input  full, almost_full, rd_data, rd_valid, data_valid, count, overflow
    );

    modport slave (
        input  clear, wr_en, wr_data, lockstep, rd_en, rd_ready,
        output full, almost_full, rd_data, rd_valid, data_valid, count, overflow
    );

endinterface

// File: rtl/pe_row_fifo.sv
// Single row FIFO: storage, wrap-around pointers, separate occupancy count and
// a registered pop port. Pop requests arrive already arbitrated by the bank.
module pe_row_fifo
    import pe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COLS       = 7,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = DEPTH - 2,
    parameter int CW         = cw_calc(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_clear,
    input  logic                             i_wr_en,
    input  logic [COLS-1:0][DATA_WIDTH-1:0]  i_wr_data,
    input  logic                             i_pop,
    output logic [COLS-1:0][DATA_WIDTH-1:0]  o_rd_data,
    output logic                             o_rd_valid,
    output logic [CW-1:0]                    o_count,
    output logic                             o_full,
    output logic                             o_empty,
    output logic                             o_almost_full,
    output logic                             o_push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [COLS-1:0][DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]                   r_wr_ptr;
    logic [AW-1:0]                   r_rd_ptr;
    logic [CW-1:0]                   r_count;
    logic [COLS-1:0][DATA_WIDTH-1:0] r_rd_data;
    logic                            r_rd_valid;

    logic w_push;
    logic w_pop;

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_almost_full = (r_count >= CW'(AFULL_TH));
    assign o_push_drop   = i_wr_en & o_full;

    assign w_push = i_wr_en & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // NOTE: storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;

endmodule

// File: rtl/pe_row_fifo_bank.sv
// Bank of ROWS row FIFOs between the PE array and the row buffer, with
// independent or lockstep popping and a sticky overflow flag.
module pe_row_fifo_bank
    import pe_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 2,
    parameter int COLS       = 7,
    parameter int DEPTH      = 16,
    parameter int AFULL_TH   = DEPTH - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_row_fifo_bank_if.slave bus
);

    localparam int CW = cw_calc(DEPTH);

    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] w_rd_data;
    logic [ROWS-1:0]                           w_rd_valid;
    logic [ROWS-1:0][CW-1:0]                   w_count;
    logic [ROWS-1:0]                           w_full;
    logic [ROWS-1:0]                           w_empty;
    logic [ROWS-1:0]                           w_almost_full;
    logic [ROWS-1:0]                           w_push_drop;
    logic [ROWS-1:0]                           w_pop;
    logic                                      w_grant;
    pop_mode_e                                 w_mode;
    logic                                      r_overflow;

    assign w_mode = pop_mode_e'(bus.lockstep);

    // Lockstep: one empty requested row stalls every requested row.
    assign w_grant = bus.rd_ready & (|bus.rd_en) & ~(|(bus.rd_en & w_empty));

    always_comb begin
        w_pop = '0;
        if (w_mode == POP_LOCKSTEP) begin
            w_pop = {ROWS{w_grant}} & bus.rd_en;
        end else begin
            w_pop = {ROWS{bus.rd_ready}} & bus.rd_en & ~w_empty;
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        pe_row_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .COLS       (COLS),
            .DEPTH      (DEPTH),
            .AFULL_TH   (AFULL_TH),
            .CW         (CW)
        ) u_fifo (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_clear       (bus.clear),
            .i_wr_en       (bus.wr_en[g]),
            .i_wr_data     (bus.wr_data[g]),
            .i_pop         (w_pop[g]),
            .o_rd_data     (w_rd_data[g]),
            .o_rd_valid    (w_rd_valid[g]),
            .o_count       (w_count[g]),
            .o_full        (w_full[g]),
            .o_empty       (w_empty[g]),
            .o_almost_full (w_almost_full[g]),
            .o_push_drop   (w_push_drop[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
        end else if (|w_push_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.rd_data     = w_rd_data;
    assign bus.rd_valid    = w_rd_valid;
    assign bus.data_valid  = |w_rd_valid;
    assign bus.count       = w_count;
    assign bus.full        = w_full;
    assign bus.almost_full = w_almost_full;
    assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_pe_row_fifo_bank.sv
// Self-checking bench: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_row_fifo_bank;

    localparam int DW       = 8;
    localparam int ROWS     = 2;
    localparam int COLS     = 3;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;
    localparam int W        = ROWS * COLS * DW;

    typedef logic [COLS-1:0][DW-1:0] vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pe_row_fifo_bank_if #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) bus ();

    pe_row_fifo_bank #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DEPTH      (DEPTH),
        .AFULL_TH   (AFULL_TH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    vec_t                            m_q [ROWS][$];
    logic [ROWS-1:0][COLS-1:0][DW-1:0] m_rd_data;
    logic [ROWS-1:0]                 m_rd_valid;
    logic                            m_ovf;
    logic                            m_blocked;
    logic                            m_do_pop;
    logic                            m_room;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) m_q[r].delete();
            m_rd_data  = '0;
            m_rd_valid = '0;
            m_ovf      = 1'b0;
        end else if (bus.clear) begin
            for (int r = 0; r < ROWS; r++) m_q[r].delete();
            m_rd_valid = '0;
            m_ovf      = 1'b0;
        end else begin
            m_blocked = 1'b0;
            for (int r = 0; r < ROWS; r++)
                if (bus.rd_en[r] && m_q[r].size() == 0) m_blocked = 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                if (bus.lockstep)
                    m_do_pop = bus.rd_ready && (bus.rd_en != '0) && !m_blocked && bus.rd_en[r];
                else
                    m_do_pop = bus.rd_ready && bus.rd_en[r] && (m_q[r].size() != 0);
                m_room = (m_q[r].size() < DEPTH);
                if (bus.wr_en[r] && !m_room) m_ovf = 1'b1;
                if (m_do_pop) m_rd_data[r] = m_q[r].pop_front();
                m_rd_valid[r] = m_do_pop;
                if (bus.wr_en[r] && m_room) m_q[r].push_back(bus.wr_data[r]);
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        logic [ROWS-1:0] e_full;
        logic [ROWS-1:0] e_af;
        for (int r = 0; r < ROWS; r++) begin
            e_full[r] = (m_q[r].size() == DEPTH);
            e_af[r]   = (m_q[r].size() >= AFULL_TH);
            check($sformatf("model count[%0d]", r), 64'(bus.count[r]), 64'(m_q[r].size()));
        end
        check("model full",        64'(bus.full),        64'(e_full));
        check("model almost_full", 64'(bus.almost_full), 64'(e_af));
        check("model rd_valid",    64'(bus.rd_valid),    64'(m_rd_valid));
        check("model data_valid",  64'(bus.data_valid),  64'(|m_rd_valid));
        check("model rd_data",     64'(bus.rd_data),     64'(m_rd_data));
        check("model overflow",    64'(bus.overflow),    64'(m_ovf));
    end

    // ---------------- stimulus ----------------
    function automatic vec_t mk(input logic [DW-1:0] v);
        vec_t x;
        for (int c = 0; c < COLS; c++) x[c] = v;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear    = 1'b0;
        bus.wr_en    = '0;
        bus.rd_en    = '0;
        bus.rd_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n        = 1'b0;
        bus.lockstep = 1'b0;
        bus.clear    = 1'b0;
        bus.wr_en    = '1;
        bus.wr_data  = W'({$urandom(), $urandom()});
        bus.rd_en    = '1;
        bus.rd_ready = 1'b1;

        // Reset held with pushes requested.
        tick(); tick();
        check("reset count",      64'(bus.count), 64'd0);
        check("reset rd_valid",   64'(bus.rd_valid), 64'd0);
        check("reset data_valid", 64'(bus.data_valid), 64'd0);
        check("reset rd_data",    64'(bus.rd_data), 64'd0);
        check("reset full",       64'(bus.full), 64'd0);
        check("reset afull",      64'(bus.almost_full), 64'd0);
        check("reset overflow",   64'(bus.overflow), 64'd0);
        idle();
        rst_n = 1'b1;
        tick();
        check("post-reset count", 64'(bus.count), 64'd0);

        // Fill both rows with 1..5; fifth push overflows.
        bus.wr_en = 2'b11;
        for (int i = 1; i <= 5; i++) begin
            bus.wr_data[0] = mk(DW'(i));
            bus.wr_data[1] = mk(DW'(i + 16));
            tick();
            if (i == 2) check("afull after 2 pushes", 64'(bus.almost_full), 64'd0);
            if (i == 3) check("afull after 3 pushes", 64'(bus.almost_full), 64'h3);
        end
        bus.wr_en = '0;
        check("fill full",     64'(bus.full), 64'h3);
        check("fill overflow", 64'(bus.overflow), 64'd1);
        check("fill count0",   64'(bus.count[0]), 64'd4);
        check("fill count1",   64'(bus.count[1]), 64'd4);

        // Drain in order.
        bus.rd_en = 2'b11;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("drain rd_data0 #%0d", i), 64'(bus.rd_data[0]), 64'(mk(DW'(i))));
            check($sformatf("drain rd_data1 #%0d", i), 64'(bus.rd_data[1]), 64'(mk(DW'(i + 16))));
            check($sformatf("drain rd_valid #%0d", i), 64'(bus.rd_valid), 64'h3);
            if (i == 1) check("afull at count 3", 64'(bus.almost_full), 64'h3);
            if (i == 2) check("afull at count 2", 64'(bus.almost_full), 64'd0);
        end
        bus.rd_en = '0;
        tick();
        check("drained rd_valid", 64'(bus.rd_valid), 64'd0);
        check("drained count",    64'(bus.count), 64'd0);

        // Lockstep blocked by empty row1.
        bus.lockstep = 1'b1;
        bus.wr_en    = 2'b01;
        bus.wr_data[0] = mk(8'h21); tick();
        bus.wr_data[0] = mk(8'h22); tick();
        bus.wr_en = '0;
        bus.rd_en = 2'b11;
        tick();
        check("lockstep blocked rd_valid", 64'(bus.rd_valid), 64'd0);
        check("lockstep blocked count0",   64'(bus.count[0]), 64'd2);
        bus.wr_en = 2'b10;
        bus.wr_data[1] = mk(8'h31);
        tick();
        check("lockstep push cycle rd_valid", 64'(bus.rd_valid), 64'd0);
        bus.wr_en = '0;
        tick();
        check("lockstep grant rd_valid", 64'(bus.rd_valid), 64'h3);
        check("lockstep grant rd_data0", 64'(bus.rd_data[0]), 64'(mk(8'h21)));
        check("lockstep grant rd_data1", 64'(bus.rd_data[1]), 64'(mk(8'h31)));
        check("lockstep grant count0",   64'(bus.count[0]), 64'd1);
        bus.rd_en    = '0;
        bus.lockstep = 1'b0;

        // Bring both rows to 2, then stream push+pop across pointer wrap.
        bus.wr_en = 2'b11;
        bus.wr_data[0] = mk(8'h40); bus.wr_data[1] = mk(8'h50);
        tick();
        bus.wr_en = 2'b10;
        bus.wr_data[1] = mk(8'h51);
        tick();
        bus.wr_en = 2'b11;
        bus.rd_en = 2'b11;
        for (int i = 0; i < 10; i++) begin
            bus.wr_data = W'({$urandom(), $urandom()});
            tick();
            check($sformatf("stream count #%0d", i), 64'(bus.count), 64'({3'd2, 3'd2}));
        end

        // Clear with pending push and pop.
        bus.clear = 1'b1;
        tick();
        check("clear count",    64'(bus.count), 64'd0);
        check("clear rd_valid", 64'(bus.rd_valid), 64'd0);
        check("clear overflow", 64'(bus.overflow), 64'd0);
        bus.clear = 1'b0;
        bus.wr_en = '0;
        tick();
        check("post-clear rd_valid", 64'(bus.rd_valid), 64'd0);
        check("post-clear count",    64'(bus.count), 64'd0);

        // Randomized traffic with one asynchronous mid-cycle reset.
        for (int i = 0; i < 600; i++) begin
            bus.clear    = ($urandom_range(31) == 0);
            bus.lockstep = ($urandom_range(1) == 1);
            bus.wr_en    = ROWS'($urandom());
            bus.rd_en    = ROWS'($urandom());
            bus.rd_ready = ($urandom_range(3) != 0);
            bus.wr_data  = W'({$urandom(), $urandom()});
            if (i == 300) begin
                #2 rst_n = 1'b0;
                #1 check("async reset count", 64'(bus.count), 64'd0);
                check("async reset rd_valid", 64'(bus.rd_valid), 64'd0);
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pe_row_fifo_bank.md
# pe_row_fifo_bank

Parametrised bank of ROWS independent FIFOs buffering PE output pixel vectors (COLS pixels of DATA_WIDTH bits per entry) ahead of the row buffer. Sits between the PE array (push side) and the row-buffer reader (pop side). Generalises the fixed two-row PE-to-row-buffer handshake with:
- configurable depth;
- per-row occupancy and almost-full reporting;
- a runtime lockstep/independent pop mode;
- a sticky overflow flag and a synchronous flush.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per pixel
- ROWS, 2, number of row FIFOs (≥1)
- COLS, 7, pixels per FIFO entry (≥1)
- DEPTH, 16, entries per FIFO; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when count ≥ AFULL_TH

Ports (CW = $clog2(DEPTH+1)):
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of all rows
- wr_en  in  ROWS  per-row push request
- wr_data  in  [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]  push data per row
- full  out  ROWS  row at DEPTH entries
- almost_full  out  ROWS  count ≥ AFULL_TH
- lockstep  in  1  1 = rows selected by rd_en pop together; 0 = independent
- rd_en  in  ROWS  per-row pop request from row buffer
- rd_ready  in  1  row buffer able to accept data this cycle
- rd_data  out  [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]  registered pop data
- rd_valid  out  ROWS  per-row one-cycle valid for rd_data
- data_valid  out  1  OR of rd_valid
- count  out  [ROWS-1:0][CW-1:0]  per-row occupancy
- overflow  out  1  sticky: push attempted on a full row

## Operation
- empty[r] = (count[r]==0); full[r] = (count[r]==DEPTH). Both combinational from registered count.
- Push: accepted iff wr_en[r] & ~full[r]. Data is written at wr_ptr[r], which then increments modulo DEPTH.
- A push on a full row is dropped (FIFO contents unchanged) and sets overflow. This holds even if the row pops the same cycle.
- Independent pop (lockstep=0): pop[r] = rd_ready & rd_en[r] & ~empty[r].
- Lockstep pop (lockstep=1): grant = rd_ready & (rd_en≠0) & no row with rd_en[r]=1 is empty. Then pop[r] = grant & rd_en[r]. If any requested row is empty, no row pops.
- On pop[r]: rd_data[r] ← mem[r][rd_ptr[r]] and rd_ptr[r] increments modulo DEPTH.
- rd_valid[r] is registered pop[r]. Rows not popped hold their rd_data.
- count[r] update per cycle:
  - +1 for an accepted push only;
  - −1 for a pop only;
  - unchanged for both or neither.
- Pop on an empty row is ignored; no underflow flag.
- clear (highest priority after reset) zeroes pointers, count, rd_valid and overflow. Push/pop in the clear cycle is discarded; rd_data holds.
- overflow is cleared only by rst_n or clear.
- Pointer wrap uses log2(DEPTH) bits. count is tracked separately, so full and empty are unambiguous.

## Timing
- Reset values (rst_n=0, asynchronous):
  - rd_data=0, rd_valid=0, data_valid=0, count=0, overflow=0;
  - full=0, almost_full=0 (0 when AFULL_TH>0).
- Pop latency: pop in cycle N gives rd_data/rd_valid in N+1.
- Push to earliest data: push in cycle N, count visible N+1, earliest pop N+1, rd_valid N+2.
- full/almost_full reflect count after the previous edge; there is no same-cycle bypass.
- Back-to-back pops at one per cycle per row are sustained while non-empty.
- rd_ready low: no pops; rd_valid falls the next cycle.
- Reset asserted mid-operation: all state is cleared immediately, independent of clk.

## Structure
- Package pe_fifo_pkg holds:
  - pixel vector typedef ([COLS-1:0][DATA_WIDTH-1:0]) as a parameterised-width helper;
  - CW computation function.
- Sub-module pe_row_fifo: one FIFO with memory, pointers, count, full/empty and push/pop. It is instantiated ROWS times in a generate loop.
- Top level holds the lockstep grant logic, the overflow OR and the data_valid OR.

## Test plan
- Reset: hold rst_n=0 with wr_en all 1 → all outputs 0; after release, count=0 and empty.
- Fill then drain, ROWS=2, DEPTH=4, lockstep=0:
  - push rows 0 and 1 five times with values 1..5 → full=2'b11, overflow=1, count=4 each;
  - pop 4 times → rd_data 1,2,3,4 in order, each the cycle after pop.
- Lockstep block: row0 has 2 entries, row1 empty, rd_en=2'b11, rd_ready=1 → no pops, rd_valid=0. Push row1 once → next eligible cycle both rows pop and rd_valid=2'b11.
- Simultaneous push/pop at count=2 → count stays 2; data order preserved across pointer wrap after 10 cycles of streaming.
- clear with pending push and pop → count=0, rd_valid=0 next cycle, overflow=0; the pushed word is not stored.
- almost_full with AFULL_TH=3, DEPTH=4: asserts the cycle after the 3rd push and deasserts after the pop that brings count to 2.
